// File: rtl/data_mem_controller.sv
// Data-memory controller: aligns MEM-stage loads/stores onto a word-wide req/ready memory port.
// One request in flight; the pipeline is stalled from request through ACCESS, released in DONE.
module data_mem_controller #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        misaligned,
  output logic        accessFault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_load_q, is_load_d;
  logic [2:0]     f3_q, f3_d;
  logic [1:0]     off_q, off_d;
  logic           mem_we_q, mem_we_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [31:0]    mem_wdata_q, mem_wdata_d;
  logic [3:0]     mem_wstrb_q, mem_wstrb_d;
  logic [31:0]    load_data_q, load_data_d;
  logic           load_valid_q, load_valid_d;
  logic           misaligned_q, misaligned_d;
  logic           access_fault_q, access_fault_d;

  logic        req, is_byte, is_half, aligned, start;
  logic [31:0] st_wdata;
  logic [3:0]  st_strb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request decode; funct3 codes other than B/H/BU/HU behave as a word access.
  always_comb begin
    req     = memRead | memWrite;
    is_byte = (funct3 == 3'b000) || (funct3 == 3'b100);
    is_half = (funct3 == 3'b001) || (funct3 == 3'b101);
    if (is_byte)      aligned = 1'b1;
    else if (is_half) aligned = ~address[0];
    else              aligned = (address[1:0] == 2'b00);
    start = (state_q == IDLE) && req && aligned;

    if (is_byte) begin
      st_wdata = {4{writeData[7:0]}};
      st_strb  = 4'b0001 << address[1:0];
    end else if (is_half) begin
      st_wdata = {2{writeData[15:0]}};
      st_strb  = 4'b0011 << address[1:0];
    end else begin
      st_wdata = writeData;
      st_strb  = 4'b1111;
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    is_load_d      = is_load_q;
    f3_d           = f3_q;
    off_d          = off_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_wstrb_d    = mem_wstrb_q;
    load_data_d    = load_data_q;
    load_valid_d   = 1'b0;
    misaligned_d   = 1'b0;
    access_fault_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req && !aligned) begin
          misaligned_d = 1'b1;
        end else if (start) begin
          state_d     = ACCESS;
          cnt_d       = '0;
          is_load_d   = memRead;
          f3_d        = funct3;
          off_d       = address[1:0];
          mem_we_d    = ~memRead;
          mem_addr_d  = {address[31:2], 2'b00};
          mem_wdata_d = st_wdata;
          mem_wstrb_d = memRead ? 4'b0000 : st_strb;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d = DONE;
          if (is_load_q) begin
            load_data_d  = ld_ext;
            load_valid_d = 1'b1;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Abandon the access: report a fault and return a zero load result.
          state_d        = DONE;
          load_data_d    = '0;
          access_fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      is_load_q      <= 1'b0;
      f3_q           <= 3'b000;
      off_q          <= 2'b00;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wstrb_q    <= 4'b0000;
      load_data_q    <= '0;
      load_valid_q   <= 1'b0;
      misaligned_q   <= 1'b0;
      access_fault_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      is_load_q      <= is_load_d;
      f3_q           <= f3_d;
      off_q          <= off_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wstrb_q    <= mem_wstrb_d;
      load_data_q    <= load_data_d;
      load_valid_q   <= load_valid_d;
      misaligned_q   <= misaligned_d;
      access_fault_q <= access_fault_d;
    end
  end

  assign mem_req     = (state_q == ACCESS);
  assign stall       = start || (state_q == ACCESS);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign loadData    = load_data_q;
  assign loadValid   = load_valid_q;
  assign misaligned  = misaligned_q;
  assign accessFault = access_fault_q;

endmodule

// File: doc/data_mem_controller.md
DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum ACCESS cycles before the access is abandoned.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 memRead  input  1  MEM-stage load request.
REQ-005 memWrite  input  1  MEM-stage store request.
REQ-006 funct3  input  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 address  input  32  byte address from the ALU.
REQ-008 writeData  input  32  store data, right-aligned.
REQ-009 stall  output  1  freezes the pipeline while an access is in flight.
REQ-010 loadData  output  32  aligned, extended load result (registered).
REQ-011 loadValid  output  1  one-cycle pulse when loadData is valid.
REQ-012 misaligned  output  1  one-cycle pulse for a misaligned request.
REQ-013 accessFault  output  1  one-cycle pulse on timeout.
REQ-014 mem_req  output  1  memory request, held until mem_ready.
REQ-015 mem_we  output  1  1 = write.
REQ-016 mem_addr  output  32  {address[31:2],2'b00}.
REQ-017 mem_wdata  output  32  lane-replicated store data.
REQ-018 mem_wstrb  output  4  byte enables; 0000 on reads.
REQ-019 mem_rdata  input  32  read word.
REQ-020 mem_ready  input  1  completion for the current request, sampled only while mem_req=1.

Function
REQ-021 The FSM SHALL use states IDLE, ACCESS and DONE.
REQ-022 IDLE->ACCESS SHALL occur when (memRead|memWrite)=1 and the request is aligned; mem_req SHALL assert in the first ACCESS cycle.
REQ-023 When both memRead and memWrite are 1, the request SHALL be treated as a load.
REQ-024 Alignment rules:
- H/HU SHALL require address[0]=0.
- W SHALL require address[1:0]=00.
- B SHALL always be aligned.
- Undefined funct3 values SHALL be treated as W.
REQ-025 A misaligned request SHALL pulse misaligned for one cycle, stay in IDLE, keep mem_req=0 and keep stall=0.
REQ-026 ACCESS SHALL hold mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb stable, latched at the IDLE->ACCESS edge, until mem_ready=1.
REQ-027 On mem_ready=1 in ACCESS:
- The next state SHALL be DONE.
- For loads, loadData SHALL be captured.
- mem_req SHALL deassert in DONE.
REQ-028 mem_ready=1 in the same cycle as the ACCESS entry edge SHALL NOT be honoured; minimum latency is request cycle to DONE = 2 cycles.
REQ-029 stall SHALL be combinational:
- 1 in IDLE with a valid aligned request.
- 1 throughout ACCESS.
- 0 in DONE.
REQ-030 DONE SHALL last exactly one cycle:
- loadValid=1 for loads only.
- Next state SHALL be IDLE.
REQ-031 Load extraction: byte = mem_rdata[8*off+7:8*off], half = mem_rdata[16*off1+15:16*off1], where off = address[1:0] and off1 = address[1].
REQ-032 Load extension: B/H SHALL sign-extend; BU/HU SHALL zero-extend; W SHALL pass through.
REQ-033 Store lanes:
- SB: wdata={4{writeData[7:0]}}, wstrb=0001<<off.
- SH: wdata={2{writeData[15:0]}}, wstrb=0011<<off.
- SW: wdata=writeData, wstrb=1111.
REQ-034 An ACCESS cycle counter SHALL reach TIMEOUT without mem_ready, then:
- mem_req SHALL drop.
- State SHALL go to DONE.
- accessFault SHALL pulse.
- loadData SHALL be 0 and loadValid SHALL be 0.
REQ-035 The cycle counter SHALL clear on ACCESS entry.
REQ-036 loadData SHALL hold its last value outside DONE.

Reset
REQ-037 reset_n=0 SHALL force the following immediately and asynchronously, including mid-ACCESS:
- state IDLE and counter 0.
- mem_req=0, mem_we=0, mem_wstrb=0000.
- loadData=0.
- loadValid, misaligned, accessFault = 0.
REQ-038 After reset_n rises, the first request SHALL be accepted on the next rising edge.

Verification
REQ-039 LB, address=0x103, mem_rdata=0xDEADBEEF, mem_ready after 2 wait cycles -> mem_addr=0x100, loadData=0xFFFFFFDE, loadValid one pulse, stall high 4 cycles.
REQ-040 LHU, address=0x102, mem_rdata=0xCAFEBABE, mem_ready=1 constantly -> loadData=0x0000CAFE, DONE 2 cycles after request.
REQ-041 SB, address=0x201, writeData=0x000000AB -> mem_we=1, mem_wdata=0xABABABAB, mem_wstrb=0010, loadValid=0.
REQ-042 LW, address=0x102 -> misaligned pulse, mem_req never asserts, stall=0.
REQ-043 TIMEOUT=4, LW with mem_ready held 0 -> mem_req drops after 4 ACCESS cycles, accessFault pulse, loadData=0.
REQ-044 reset_n pulsed low mid-ACCESS -> mem_req=0 and stall=0 before the next clock edge; a new LW is then accepted normally.
